// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// hazard_sb : forwarding, load-use scoreboard, divider occupancy and
//             stall/flush generation for the 5-stage F/D/E/M/W pipeline.
// Revision  : 1.0
// ============================================================================
module hazard_sb #(
  parameter int AW         = 5,
  parameter int LOAD_LAT   = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic          memtoregD,
  input  logic [AW-1:0] writeregD,
  input  logic [AW-1:0] writeregE,
  input  logic [AW-1:0] writeregM,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          div_startE,
  input  logic          stall_all,
  input  logic          isexc,
  input  logic          pmisM,
  output logic [1:0]    forwardaD,
  output logic [1:0]    forwardbD,
  output logic          stallFD,
  output logic          stallDE,
  output logic          stallEM,
  output logic          stallMW,
  output logic          flushFD,
  output logic          flushDE,
  output logic          flushEM,
  output logic          flushMW,
  output logic          div_busy
);

  localparam int NREG = 2**AW;
  localparam int CW   = $clog2(LOAD_LAT + 2);
  localparam int DW   = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV_CYCLES - 1);

  logic [NREG-1:0][CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0]           div_cnt;
  logic                    pend_exc, pend_pmis;
  logic                    eff_exc, eff_pmis, abort;
  logic                    busy_raw, luse, stall_fd_raw, flush_de_raw;
  logic                    adv_d, set_ld;

  assign forwardaD = (rsD == '0)                     ? 2'b00 :
                     (regwriteE && rsD == writeregE) ? 2'b01 :
                     (regwriteM && rsD == writeregM) ? 2'b10 : 2'b00;
  assign forwardbD = (rtD == '0)                     ? 2'b00 :
                     (regwriteE && rtD == writeregE) ? 2'b01 :
                     (regwriteM && rtD == writeregM) ? 2'b10 : 2'b00;

  // Requests raised under stall_all are remembered and released on the first free cycle.
  assign eff_exc  = isexc | pend_exc;
  assign eff_pmis = pmisM | pend_pmis;
  assign abort    = (eff_exc | eff_pmis) & ~stall_all;

  assign busy_raw = ~abort & ((div_cnt != '0) | div_startE);
  assign luse     = ((rsD != '0) && (cnt[rsD] != '0)) ||
                    ((rtD != '0) && (cnt[rtD] != '0));

  assign stall_fd_raw = (luse | busy_raw | stall_all) & ~eff_exc;
  assign flush_de_raw = (eff_exc | eff_pmis | (luse & ~busy_raw)) & ~stall_all;
  assign adv_d        = ~stall_fd_raw & ~stall_all & ~flush_de_raw;
  assign set_ld       = adv_d & memtoregD & (writeregD != '0);

  assign stallFD  = ~rst & stall_fd_raw;
  assign stallDE  = ~rst & (stall_all | busy_raw);
  assign stallEM  = ~rst & stall_all;
  assign stallMW  = ~rst & stall_all;
  assign flushFD  = ~rst & eff_exc & ~stall_all;
  assign flushDE  = ~rst & flush_de_raw;
  assign flushEM  = ~rst & (eff_exc | busy_raw) & ~stall_all;
  assign flushMW  = 1'b0;
  assign div_busy = ~rst & busy_raw;

  // Entry 0 is never loaded, so it stays at its reset value of zero.
  // A mispredict squashes only the load just issued into E (count still at its load value).
  always_comb begin
    cnt_nxt = cnt;
    if (!stall_all) begin
      for (int r = 1; r < NREG; r++) begin
        if (eff_exc)
          cnt_nxt[r] = '0;
        else if (set_ld && writeregD == AW'(r))
          cnt_nxt[r] = CNT_LOAD;
        else if (eff_pmis && cnt[r] == CNT_LOAD)
          cnt_nxt[r] = '0;
        else if (cnt[r] != '0)
          cnt_nxt[r] = cnt[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  // Divider occupancy runs on its own clock budget, independent of stall_all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (abort)
      div_cnt <= '0;
    else if (div_cnt != '0)
      div_cnt <= div_cnt - DW'(1);
    else if (div_startE)
      div_cnt <= DIV_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_exc  <= 1'b0;
      pend_pmis <= 1'b0;
    end else if (stall_all) begin
      pend_exc  <= pend_exc | isexc;
      pend_pmis <= pend_pmis | pmisM;
    end else begin
      pend_exc  <= 1'b0;
      pend_pmis <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb.sv
`default_nettype none
// tb_hazard_sb : two instances (LOAD_LAT=1 and LOAD_LAT=3, DIV_CYCLES=4) share
// stimulus; each step's expected outputs go through a scoreboard queue.
module tb_hazard_sb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rsD = '0, rtD = '0, writeregD = '0, writeregE = '0, writeregM = '0;
  logic       memtoregD = 1'b0, regwriteE = 1'b0, regwriteM = 1'b0;
  logic       div_startE = 1'b0, stall_all = 1'b0, isexc = 1'b0, pmisM = 1'b0;

  logic [1:0] fa_a, fb_a, fa_b, fb_b;
  logic sfd_a, sde_a, sem_a, smw_a, ffd_a, fde_a, fem_a, fmw_a, busy_a;
  logic sfd_b, sde_b, sem_b, smw_b, ffd_b, fde_b, fem_b, fmw_b, busy_b;
  logic [12:0] oa, ob;

  // {fwdA, fwdB, stallFD/DE/EM/MW, flushFD/DE/EM/MW, div_busy}
  assign oa = {fa_a, fb_a, sfd_a, sde_a, sem_a, smw_a, ffd_a, fde_a, fem_a, fmw_a, busy_a};
  assign ob = {fa_b, fb_b, sfd_b, sde_b, sem_b, smw_b, ffd_b, fde_b, fem_b, fmw_b, busy_b};

  hazard_sb #(.AW(5), .LOAD_LAT(1), .DIV_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .memtoregD(memtoregD),
    .writeregD(writeregD), .writeregE(writeregE), .writeregM(writeregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .div_startE(div_startE),
    .stall_all(stall_all), .isexc(isexc), .pmisM(pmisM),
    .forwardaD(fa_a), .forwardbD(fb_a), .stallFD(sfd_a), .stallDE(sde_a),
    .stallEM(sem_a), .stallMW(smw_a), .flushFD(ffd_a), .flushDE(fde_a),
    .flushEM(fem_a), .flushMW(fmw_a), .div_busy(busy_a));

  hazard_sb #(.AW(5), .LOAD_LAT(3), .DIV_CYCLES(4)) u_b (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .memtoregD(memtoregD),
    .writeregD(writeregD), .writeregE(writeregE), .writeregM(writeregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .div_startE(div_startE),
    .stall_all(stall_all), .isexc(isexc), .pmisM(pmisM),
    .forwardaD(fa_b), .forwardbD(fb_b), .stallFD(sfd_b), .stallDE(sde_b),
    .stallEM(sem_b), .stallMW(smw_b), .flushFD(ffd_b), .flushDE(fde_b),
    .flushEM(fem_b), .flushMW(fmw_b), .div_busy(busy_b));

  always #5 clk = ~clk;

  localparam logic [12:0] Z     = 13'b00_00_0000_0000_0;
  localparam logic [12:0] LUSE  = 13'b00_00_1000_0100_0;
  localparam logic [12:0] DIVB  = 13'b00_00_1100_0010_1;
  localparam logic [12:0] STALL = 13'b00_00_1111_0000_0;
  localparam logic [12:0] EXST  = 13'b00_00_0111_0000_0;
  localparam logic [12:0] EXREL = 13'b00_00_0000_1110_0;
  localparam logic [12:0] PMIS  = 13'b00_00_0000_0100_0;
  localparam logic [12:0] F1    = 13'b01_01_0000_0000_0;
  localparam logic [12:0] F2    = 13'b00_01_0000_0000_0;
  localparam logic [12:0] F3    = 13'b10_00_0000_0000_0;
  localparam logic [12:0] F4    = 13'b01_10_0000_0000_0;

  typedef struct {
    string       name;
    logic [4:0]  rs, rt, wd, we, wm;
    logic        ld, rwe, rwm, dv, st, ex, pm;
    logic [12:0] ea, eb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(input string n, input int rs, input int rt, input int ld,
                              input int wd, input int we, input int wm, input int rwe,
                              input int rwm, input int dv, input int st, input int ex,
                              input int pm, input logic [12:0] ea, input logic [12:0] eb);
    vec_t v;
    v.name = n;  v.rs = 5'(rs); v.rt = 5'(rt); v.ld = 1'(ld); v.wd = 5'(wd);
    v.we = 5'(we); v.wm = 5'(wm); v.rwe = 1'(rwe); v.rwm = 1'(rwm); v.dv = 1'(dv);
    v.st = 1'(st); v.ex = 1'(ex); v.pm = 1'(pm); v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string n, input logic [12:0] got, input logic [12:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %b expected %b", n, got, want);
  endtask

  task automatic drive(input vec_t v);
    rsD = v.rs; rtD = v.rt; memtoregD = v.ld; writeregD = v.wd; writeregE = v.we;
    writeregM = v.wm; regwriteE = v.rwe; regwriteM = v.rwm; div_startE = v.dv;
    stall_all = v.st; isexc = v.ex; pmisM = v.pm;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check({e.name, "_ll1"}, oa, e.ea);
    check({e.name, "_ll3"}, ob, e.eb);
  endtask

  initial begin
    //               name      rs rt ld wd we wm rwe rwm dv st ex pm  expA   expB
    vecs.push_back(mk("fwd_e",   7, 7, 0, 0, 7, 7, 1, 1, 0, 0, 0, 0, F1,    F1));
    vecs.push_back(mk("fwd_r0",  0, 7, 0, 0, 7, 7, 1, 1, 0, 0, 0, 0, F2,    F2));
    vecs.push_back(mk("fwd_m",   3, 4, 0, 0, 3, 3, 0, 1, 0, 0, 0, 0, F3,    F3));
    vecs.push_back(mk("fwd_em",  4, 3, 0, 0, 4, 3, 1, 1, 0, 0, 0, 0, F4,    F4));
    vecs.push_back(mk("lu_ld",   0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("lu_t1",   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUSE,  LUSE));
    vecs.push_back(mk("lu_t2",   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUSE,  LUSE));
    vecs.push_back(mk("lu_t3",   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("lu_t4",   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("lu_t5",   5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("sa_ld",   0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("sa_t1",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUSE,  LUSE));
    vecs.push_back(mk("sa_hold1",0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, STALL, STALL));
    vecs.push_back(mk("sa_hold2",0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, STALL, STALL));
    vecs.push_back(mk("sa_t4",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LUSE,  LUSE));
    vecs.push_back(mk("sa_t5",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("sa_t6",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("sa_t7",   0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("dv_t0",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DIVB,  DIVB));
    vecs.push_back(mk("dv_t1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DIVB,  DIVB));
    vecs.push_back(mk("dv_t2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DIVB,  DIVB));
    vecs.push_back(mk("dv_t3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DIVB,  DIVB));
    vecs.push_back(mk("dv_t4",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("ex_ld",   0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("ex_s1",   8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, EXST,  EXST));
    vecs.push_back(mk("ex_s2",   8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXST,  EXST));
    vecs.push_back(mk("ex_s3",   8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXST,  EXST));
    vecs.push_back(mk("ex_rel",  8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXREL, EXREL));
    vecs.push_back(mk("ex_clr",  8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("pm_old",  0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("pm_new",  0, 0, 1,10, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("pm_hit",  9,10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, LUSE,  LUSE));
    vecs.push_back(mk("pm_t3",   9,10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("pm_t4",   9,10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     LUSE));
    vecs.push_back(mk("pm_t5",   9,10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("ab_div",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DIVB,  DIVB));
    vecs.push_back(mk("ab_pmis", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, PMIS,  PMIS));
    vecs.push_back(mk("ab_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));
    vecs.push_back(mk("pp_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, STALL, STALL));
    vecs.push_back(mk("pp_rel",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, PMIS,  PMIS));
    vecs.push_back(mk("pp_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z,     Z));

    // Outputs must be quiet while reset is held, even with stall/exception requests.
    stall_all = 1'b1;
    isexc     = 1'b1;
    #12;
    check("rst_gate_ll1", oa, Z);
    check("rst_gate_ll3", ob, Z);
    @(negedge clk);
    stall_all = 1'b0;
    isexc     = 1'b0;
    rst       = 1'b0;
    #2;
    check("rst_state_ll1", oa, Z);
    check("rst_state_ll3", ob, Z);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    div_startE = 1'b1;
    @(negedge clk);
    div_startE = 1'b0;
    #2;
    check("mid_div_ll1", oa, DIVB);
    check("mid_div_ll3", ob, DIVB);
    rst = 1'b1;
    #1;
    check("rst_async_ll1", oa, Z);
    check("rst_async_ll3", ob, Z);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_ll1", oa, Z);
    check("post_rst_ll3", ob, Z);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
- Parametrised successor hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Keeps the combinational D-stage forwarding selects and adds a per-register load scoreboard, so load-use latency is configurable (LOAD_LAT), not fixed at one cycle.
- Adds an internal multi-cycle divider busy counter and latched pending flushes, so exceptions and mispredicts raised during stall_all are not lost.
- Drives stall/flush for every pipeline register.

Parameters:
AW, 5, register address width; NREG = 2**AW entries
LOAD_LAT, 1, cycles after M before load data reaches the regfile (write-through); legal 1..6
DIV_CYCLES, 32, divider occupancy in cycles; legal 2..64

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rsD, rtD  in  AW  D-stage source registers
memtoregD  in  1  D instruction is a load
writeregD  in  AW  D destination register
writeregE, writeregM  in  AW  E/M destination registers
regwriteE, regwriteM  in  1  E/M write enables
div_startE  in  1  div/divu in E this cycle
stall_all  in  1  global memory stall
isexc  in  1  exception committed in M
pmisM  in  1  branch mispredict resolved in M
forwardaD, forwardbD  out  2  00 regfile, 01 E result, 10 M result
stallFD, stallDE, stallEM, stallMW  out  1  hold the named pipeline register
flushFD, flushDE, flushEM, flushMW  out  1  clear the named register; flush overrides stall
div_busy  out  1  divider occupying E

Behaviour:
- Reset: scoreboard counts, div counter, pend_exc and pend_pmis all 0. All stall/flush outputs and div_busy are 0 while rst is high.
- Forwarding (combinational) for source s in {rsD, rtD}:
  - s==0 gives 00.
  - Otherwise s==writeregE & regwriteE gives 01.
  - Otherwise s==writeregM & regwriteM gives 10.
  - Otherwise 00. E has priority over M.
- Effective flush requests:
  - eff_exc = isexc | pend_exc; eff_pmis = pmisM | pend_pmis.
  - While stall_all=1: pend_exc is set by isexc and pend_pmis is set by pmisM (sticky).
  - In the first cycle with stall_all=0, both pending bits are applied and then cleared.
- Scoreboard: cnt[r], width ceil(log2(LOAD_LAT+2)).
  - advD = ~stallFD & ~stall_all & ~flushDE.
  - When advD & memtoregD & writeregD!=0: cnt[writeregD] <= LOAD_LAT+1.
  - Each cycle with stall_all=0, every other nonzero cnt decrements by 1. A set on the same entry wins over its decrement.
  - stall_all=1 freezes all counts.
  - eff_exc & ~stall_all: clear every entry.
  - eff_pmis & ~stall_all (no exception): clear only entries equal to LOAD_LAT+1, i.e. the squashed E-stage load.
  - cnt[0] is never written.
- luse = (rsD!=0 & cnt[rsD]!=0) | (rtD!=0 & cnt[rtD]!=0).
- Divider:
  - div_startE with div counter==0 and no abort loads the counter with DIV_CYCLES-1.
  - The counter decrements every cycle, ignoring stall_all.
  - div_busy = (counter!=0) | (div_startE & counter==0), giving exactly DIV_CYCLES busy cycles.
  - div_startE is ignored while counter!=0.
  - Abort = (eff_exc | eff_pmis) & ~stall_all. Abort clears the counter and forces div_busy=0 that cycle.
- Outputs:
  - stallFD = (luse | div_busy | stall_all) & ~eff_exc
  - stallDE = stall_all | div_busy
  - stallEM = stallMW = stall_all
  - flushFD = eff_exc & ~stall_all
  - flushDE = (eff_exc | eff_pmis | (luse & ~div_busy)) & ~stall_all
  - flushEM = (eff_exc | div_busy) & ~stall_all
  - flushMW = 0
- Timing: all outputs are combinational from current inputs plus registered state. No added latency.
- Reset mid-operation clears all state immediately, including any in-progress div and pending flushes.
- Integration constraint: exception refetch takes ≥ LOAD_LAT+1 cycles before the first handler instruction reaches D. This is what makes clear-all on exception safe.

Test Plan:
- LOAD_LAT=1: lw $5 leaves D at t, then add uses $5 in D. Expect stallFD=1 and flushDE=1 at t+1 and t+2; released at t+3.
- LOAD_LAT=3: same sequence. Expect 4 stall cycles; assert stall_all for 2 cycles mid-sequence and check stall length grows to 6.
- DIV_CYCLES=4: div_startE at t. Expect div_busy, stallDE and flushEM high t..t+3 and low at t+4. A second div_startE at t+1 is ignored.
- isexc pulse while stall_all=1 for 3 cycles. Expect all flushes 0 during the stall; flushFD, flushDE and flushEM =1 in the first cycle stall_all=0; scoreboard is cleared.
- pmisM during a div at t+1 with a lw pending in E. div_busy drops at t+1; only that load's entry (LOAD_LAT+1) is cleared; an older load entry survives.
- rsD=rtD=writeregE=writeregM=7 with regwriteE=regwriteM=1 gives forwardaD=forwardbD=01. Then rsD=0 gives forwardaD=00. Reset asserted mid-div gives div_busy=0 immediately.
